// File: rtl/mcp3_afu_top.sv
// OpenCAPI 3.0 AFU reduced to an MMIO slave: eight 64-bit registers
// reached by 8-byte pr_rd_mem / pr_wr_mem, with TLX credit handling.
module mcp3_afu_top #(
  parameter logic [6:0]  CMD_INIT_CREDIT  = 7'd1,
  parameter logic [6:0]  RESP_INIT_CREDIT = 7'd16,
  parameter logic [63:0] AFU_ID = 64'h0000_1014_0000_0003
) (
  input  logic         clock_afu,
  input  logic         reset,
  output logic         afu_tlx_cmd_valid,
  output logic [7:0]   afu_tlx_cmd_opcode,
  output logic [11:0]  afu_tlx_cmd_actag,
  output logic [3:0]   afu_tlx_cmd_stream_id,
  output logic [67:0]  afu_tlx_cmd_ea_or_obj,
  output logic [15:0]  afu_tlx_cmd_afutag,
  output logic [1:0]   afu_tlx_cmd_dl,
  output logic [2:0]   afu_tlx_cmd_pl,
  output logic         afu_tlx_cmd_os,
  output logic [63:0]  afu_tlx_cmd_be,
  output logic [3:0]   afu_tlx_cmd_flag,
  output logic         afu_tlx_cmd_endian,
  output logic [15:0]  afu_tlx_cmd_bdf,
  output logic [19:0]  afu_tlx_cmd_pasid,
  output logic [5:0]   afu_tlx_cmd_pg_size,
  output logic         afu_tlx_cdata_valid,
  output logic         afu_tlx_cdata_bdi,
  output logic [511:0] afu_tlx_cdata_bus,
  input  logic         tlx_afu_cmd_credit,
  input  logic         tlx_afu_cmd_data_credit,
  input  logic [2:0]   tlx_afu_cmd_resp_initial_credit,
  input  logic [4:0]   tlx_afu_data_initial_credit,
  input  logic         tlx_afu_resp_valid,
  input  logic [7:0]   tlx_afu_resp_opcode,
  input  logic [15:0]  tlx_afu_resp_afutag,
  input  logic [3:0]   tlx_afu_resp_code,
  input  logic [1:0]   tlx_afu_resp_dl,
  input  logic [1:0]   tlx_afu_resp_dp,
  input  logic [5:0]   tlx_afu_resp_pg_size,
  input  logic [17:0]  tlx_afu_resp_addr_tag,
  input  logic         tlx_afu_resp_data_valid,
  input  logic         tlx_afu_resp_data_bdi,
  input  logic [511:0] tlx_afu_resp_data_bus,
  output logic         afu_tlx_resp_rd_req,
  output logic [2:0]   afu_tlx_resp_rd_cnt,
  output logic         afu_tlx_resp_credit,
  output logic [6:0]   afu_tlx_resp_initial_credit,
  input  logic         tlx_afu_ready,
  input  logic         tlx_afu_cmd_valid,
  input  logic [7:0]   tlx_afu_cmd_opcode,
  input  logic [15:0]  tlx_afu_cmd_capptag,
  input  logic [1:0]   tlx_afu_cmd_dl,
  input  logic [2:0]   tlx_afu_cmd_pl,
  input  logic [63:0]  tlx_afu_cmd_be,
  input  logic         tlx_afu_cmd_end,
  input  logic         tlx_afu_cmd_t,
  input  logic [63:0]  tlx_afu_cmd_pa,
  input  logic [3:0]   tlx_afu_cmd_flag,
  input  logic         tlx_afu_cmd_os,
  input  logic         tlx_afu_cmd_data_valid,
  input  logic         tlx_afu_cmd_data_bdi,
  input  logic [511:0] tlx_afu_cmd_data_bus,
  output logic         afu_tlx_cmd_rd_req,
  output logic [2:0]   afu_tlx_cmd_rd_cnt,
  output logic         afu_tlx_cmd_credit,
  output logic [6:0]   afu_tlx_cmd_initial_credit,
  output logic         afu_tlx_resp_valid,
  output logic [7:0]   afu_tlx_resp_opcode,
  output logic [1:0]   afu_tlx_resp_dl,
  output logic [15:0]  afu_tlx_resp_capptag,
  output logic [1:0]   afu_tlx_resp_dp,
  output logic [3:0]   afu_tlx_resp_code,
  output logic         afu_tlx_rdata_valid,
  output logic         afu_tlx_rdata_bdi,
  output logic [511:0] afu_tlx_rdata_bus,
  input  logic         tlx_afu_resp_credit,
  input  logic         tlx_afu_resp_data_credit,
  input  logic         afu_cfg_in_rcv_tmpl_capability_0,
  input  logic         afu_cfg_in_rcv_tmpl_capability_1,
  input  logic         afu_cfg_in_rcv_tmpl_capability_2,
  input  logic         afu_cfg_in_rcv_tmpl_capability_3,
  input  logic [3:0]   afu_cfg_in_rcv_rate_capability_0,
  input  logic [3:0]   afu_cfg_in_rcv_rate_capability_1,
  input  logic [3:0]   afu_cfg_in_rcv_rate_capability_2,
  input  logic [3:0]   afu_cfg_in_rcv_rate_capability_3,
  output logic         afu_cfg_xmit_tmpl_config_0,
  output logic         afu_cfg_xmit_tmpl_config_1,
  output logic         afu_cfg_xmit_tmpl_config_2,
  output logic         afu_cfg_xmit_tmpl_config_3,
  output logic [3:0]   afu_cfg_xmit_rate_config_0,
  output logic [3:0]   afu_cfg_xmit_rate_config_1,
  output logic [3:0]   afu_cfg_xmit_rate_config_2,
  output logic [3:0]   afu_cfg_xmit_rate_config_3
);

  localparam logic [7:0] OP_WR = 8'h86;
  localparam logic [7:0] OP_RD = 8'h28;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WREQ,
    S_WDATA,
    S_RESP,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [15:0]   tag_q, tag_d;
  logic [2:0]    pl_q, pl_d;
  logic [5:0]    pa_q, pa_d;
  logic [3:0]    resp_cred_q, resp_cred_d;
  logic [5:0]    data_cred_q, data_cred_d;
  logic [63:0]   regs_q [8];
  logic [63:0]   regs_d [8];

  logic          resp_valid_q, resp_valid_d;
  logic [7:0]    resp_opcode_q, resp_opcode_d;
  logic [15:0]   resp_capptag_q, resp_capptag_d;
  logic [3:0]    resp_code_q, resp_code_d;
  logic          cmd_credit_q, cmd_credit_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic [511:0]  rdata_bus_q, rdata_bus_d;
  logic          rd_req_q, rd_req_d;
  logic [2:0]    rd_cnt_q, rd_cnt_d;
  logic          resp_echo_q, resp_echo_d;

  logic [2:0]    idx;
  logic          good;
  logic [63:0]   rd_val;
  logic          resp_ok;
  logic          data_ok;
  logic          fire;
  logic          use_resp;
  logic          use_data;

  assign idx     = pa_q[5:3];
  assign good    = (pl_q == 3'b011) && (pa_q[2:0] == 3'b000);
  assign rd_val  = (idx == 3'd7) ? AFU_ID : regs_q[idx];
  assign resp_ok = (resp_cred_q != 4'd0);
  assign data_ok = (data_cred_q != 6'd0);

  always_comb begin
    state_d        = state_q;
    is_wr_d        = is_wr_q;
    tag_d          = tag_q;
    pl_d           = pl_q;
    pa_d           = pa_q;
    regs_d         = regs_q;
    fire           = 1'b0;
    resp_valid_d   = 1'b0;
    resp_opcode_d  = 8'h00;
    resp_capptag_d = 16'h0000;
    resp_code_d    = 4'h0;
    cmd_credit_d   = 1'b0;
    rdata_valid_d  = 1'b0;
    rdata_bus_d    = '0;
    rd_req_d       = 1'b0;
    rd_cnt_d       = 3'b000;
    use_resp       = 1'b0;
    use_data       = 1'b0;
    resp_echo_d    = tlx_afu_resp_valid;

    unique case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (tlx_afu_cmd_valid && tlx_afu_ready) begin
          is_wr_d = (tlx_afu_cmd_opcode == OP_WR);
          tag_d   = tlx_afu_cmd_capptag;
          pl_d    = tlx_afu_cmd_pl;
          pa_d    = tlx_afu_cmd_pa[5:0];
          if (tlx_afu_cmd_opcode == OP_WR) begin
            state_d = S_WREQ;
          end else if (tlx_afu_cmd_opcode == OP_RD) begin
            state_d = S_RESP;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_WREQ: begin
        rd_req_d = 1'b1;
        rd_cnt_d = 3'b001;
        state_d  = S_WDATA;
      end
      // Register 7 is the read-only ID, so its write slot is dropped.
      S_WDATA: begin
        if (tlx_afu_cmd_data_valid) begin
          if (good && !tlx_afu_cmd_data_bdi && idx != 3'd7) begin
            regs_d[idx] = tlx_afu_cmd_data_bus[{idx, 6'b0} +: 64];
          end
          if (resp_ok) begin
            fire = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        fire = resp_ok && (is_wr_q || !good || data_ok);
      end
      S_DROP: begin
        cmd_credit_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fire) begin
      state_d        = S_IDLE;
      resp_valid_d   = 1'b1;
      resp_capptag_d = tag_q;
      cmd_credit_d   = 1'b1;
      use_resp       = 1'b1;
      unique case (1'b1)
        good: begin
          resp_opcode_d = is_wr_q ? 8'h04 : 8'h01;
          resp_code_d   = 4'h0;
        end
        (pl_q != 3'b011): begin
          resp_opcode_d = is_wr_q ? 8'h05 : 8'h02;
          resp_code_d   = 4'h9;
        end
        default: begin
          resp_opcode_d = is_wr_q ? 8'h05 : 8'h02;
          resp_code_d   = 4'hE;
        end
      endcase
      if (good && !is_wr_q) begin
        rdata_valid_d = 1'b1;
        rdata_bus_d[{idx, 6'b0} +: 64] = rd_val;
        use_data = 1'b1;
      end
    end

    if (state_q == S_INIT) begin
      resp_cred_d = {1'b0, tlx_afu_cmd_resp_initial_credit};
      data_cred_d = {1'b0, tlx_afu_data_initial_credit};
    end else begin
      resp_cred_d = resp_cred_q
                  + {3'b000, tlx_afu_resp_credit}
                  - {3'b000, use_resp};
      data_cred_d = data_cred_q
                  + {5'b00000, tlx_afu_resp_data_credit}
                  - {5'b00000, use_data};
    end
  end

  always_ff @(posedge clock_afu or negedge reset) begin
    if (!reset) begin
      state_q        <= S_INIT;
      is_wr_q        <= 1'b0;
      tag_q          <= 16'h0000;
      pl_q           <= 3'b000;
      pa_q           <= 6'b000000;
      resp_cred_q    <= 4'd0;
      data_cred_q    <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 64'h0;
      end
      resp_valid_q   <= 1'b0;
      resp_opcode_q  <= 8'h00;
      resp_capptag_q <= 16'h0000;
      resp_code_q    <= 4'h0;
      cmd_credit_q   <= 1'b0;
      rdata_valid_q  <= 1'b0;
      rdata_bus_q    <= '0;
      rd_req_q       <= 1'b0;
      rd_cnt_q       <= 3'b000;
      resp_echo_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_wr_q        <= is_wr_d;
      tag_q          <= tag_d;
      pl_q           <= pl_d;
      pa_q           <= pa_d;
      resp_cred_q    <= resp_cred_d;
      data_cred_q    <= data_cred_d;
      regs_q         <= regs_d;
      resp_valid_q   <= resp_valid_d;
      resp_opcode_q  <= resp_opcode_d;
      resp_capptag_q <= resp_capptag_d;
      resp_code_q    <= resp_code_d;
      cmd_credit_q   <= cmd_credit_d;
      rdata_valid_q  <= rdata_valid_d;
      rdata_bus_q    <= rdata_bus_d;
      rd_req_q       <= rd_req_d;
      rd_cnt_q       <= rd_cnt_d;
      resp_echo_q    <= resp_echo_d;
    end
  end

  assign afu_tlx_resp_valid   = resp_valid_q;
  assign afu_tlx_resp_opcode  = resp_opcode_q;
  assign afu_tlx_resp_dl      = {1'b0, resp_valid_q};
  assign afu_tlx_resp_capptag = resp_capptag_q;
  assign afu_tlx_resp_dp      = 2'b00;
  assign afu_tlx_resp_code    = resp_code_q;
  assign afu_tlx_rdata_valid  = rdata_valid_q;
  assign afu_tlx_rdata_bdi    = 1'b0;
  assign afu_tlx_rdata_bus    = rdata_bus_q;
  assign afu_tlx_cmd_rd_req   = rd_req_q;
  assign afu_tlx_cmd_rd_cnt   = rd_cnt_q;
  assign afu_tlx_cmd_credit   = cmd_credit_q;
  assign afu_tlx_resp_credit  = resp_echo_q;

  assign afu_tlx_cmd_initial_credit  = CMD_INIT_CREDIT;
  assign afu_tlx_resp_initial_credit = RESP_INIT_CREDIT;
  assign afu_tlx_resp_rd_req         = 1'b0;
  assign afu_tlx_resp_rd_cnt         = 3'b000;

  // Initiator side is idle in this slave-only build.
  assign afu_tlx_cmd_valid     = 1'b0;
  assign afu_tlx_cmd_opcode    = 8'h00;
  assign afu_tlx_cmd_actag     = 12'h000;
  assign afu_tlx_cmd_stream_id = 4'h0;
  assign afu_tlx_cmd_ea_or_obj = 68'h0;
  assign afu_tlx_cmd_afutag    = 16'h0000;
  assign afu_tlx_cmd_dl        = 2'b00;
  assign afu_tlx_cmd_pl        = 3'b000;
  assign afu_tlx_cmd_os        = 1'b0;
  assign afu_tlx_cmd_be        = 64'h0;
  assign afu_tlx_cmd_flag      = 4'h0;
  assign afu_tlx_cmd_endian    = 1'b0;
  assign afu_tlx_cmd_bdf       = 16'h0000;
  assign afu_tlx_cmd_pasid     = 20'h00000;
  assign afu_tlx_cmd_pg_size   = 6'h00;
  assign afu_tlx_cdata_valid   = 1'b0;
  assign afu_tlx_cdata_bdi     = 1'b0;
  assign afu_tlx_cdata_bus     = '0;

  assign afu_cfg_xmit_tmpl_config_0 = 1'b1;
  assign afu_cfg_xmit_tmpl_config_1 = 1'b0;
  assign afu_cfg_xmit_tmpl_config_2 = 1'b0;
  assign afu_cfg_xmit_tmpl_config_3 = 1'b0;
  assign afu_cfg_xmit_rate_config_0 = 4'h0;
  assign afu_cfg_xmit_rate_config_1 = 4'h0;
  assign afu_cfg_xmit_rate_config_2 = 4'h0;
  assign afu_cfg_xmit_rate_config_3 = 4'h0;

  logic unused_ok;
  assign unused_ok = ^{
    tlx_afu_cmd_credit, tlx_afu_cmd_data_credit,
    tlx_afu_resp_opcode, tlx_afu_resp_afutag,
    tlx_afu_resp_code, tlx_afu_resp_dl,
    tlx_afu_resp_dp, tlx_afu_resp_pg_size,
    tlx_afu_resp_addr_tag, tlx_afu_resp_data_valid,
    tlx_afu_resp_data_bdi, tlx_afu_resp_data_bus,
    tlx_afu_cmd_dl, tlx_afu_cmd_be, tlx_afu_cmd_end,
    tlx_afu_cmd_t, tlx_afu_cmd_pa[63:6],
    tlx_afu_cmd_flag, tlx_afu_cmd_os,
    afu_cfg_in_rcv_tmpl_capability_0,
    afu_cfg_in_rcv_tmpl_capability_1,
    afu_cfg_in_rcv_tmpl_capability_2,
    afu_cfg_in_rcv_tmpl_capability_3,
    afu_cfg_in_rcv_rate_capability_0,
    afu_cfg_in_rcv_rate_capability_1,
    afu_cfg_in_rcv_rate_capability_2,
    afu_cfg_in_rcv_rate_capability_3
  };

endmodule

// File: tb/tb_mcp3_afu_top.sv
// Bench for mcp3_afu_top: directed MMIO cases plus random traffic
// checked against a register-array model of the AFU.
module tb_mcp3_afu_top;

  localparam logic [63:0] AFU_ID = 64'h0000_1014_0000_0003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         o_cmd_valid, o_cmd_os, o_cmd_endian;
  logic [7:0]   o_cmd_opcode;
  logic [11:0]  o_cmd_actag;
  logic [3:0]   o_cmd_stream_id, o_cmd_flag;
  logic [67:0]  o_cmd_ea;
  logic [15:0]  o_cmd_afutag, o_cmd_bdf;
  logic [1:0]   o_cmd_dl;
  logic [2:0]   o_cmd_pl;
  logic [63:0]  o_cmd_be;
  logic [19:0]  o_cmd_pasid;
  logic [5:0]   o_cmd_pg_size;
  logic         o_cdata_valid, o_cdata_bdi;
  logic [511:0] o_cdata_bus;
  logic         i_cmd_credit = 0, i_cmd_data_credit = 0;
  logic [2:0]   i_resp_init = 0;
  logic [4:0]   i_data_init = 0;
  logic         i_resp_valid = 0;
  logic [7:0]   i_resp_opcode = 0;
  logic [15:0]  i_resp_afutag = 0;
  logic [3:0]   i_resp_code = 0;
  logic [1:0]   i_resp_dl = 0, i_resp_dp = 0;
  logic [5:0]   i_resp_pg_size = 0;
  logic [17:0]  i_resp_addr_tag = 0;
  logic         i_resp_data_valid = 0, i_resp_data_bdi = 0;
  logic [511:0] i_resp_data_bus = '0;
  logic         o_resp_rd_req;
  logic [2:0]   o_resp_rd_cnt;
  logic         o_resp_credit;
  logic [6:0]   o_resp_init_credit;
  logic         i_ready = 1;
  logic         i_cmd_valid = 0;
  logic [7:0]   i_cmd_opcode = 0;
  logic [15:0]  i_cmd_capptag = 0;
  logic [1:0]   i_cmd_dl = 0;
  logic [2:0]   i_cmd_pl = 0;
  logic [63:0]  i_cmd_be = 0;
  logic         i_cmd_end = 0, i_cmd_t = 0, i_cmd_os = 0;
  logic [63:0]  i_cmd_pa = 0;
  logic [3:0]   i_cmd_flag = 0;
  logic         i_data_valid = 0, i_data_bdi = 0;
  logic [511:0] i_data_bus = '0;
  logic         o_rd_req;
  logic [2:0]   o_rd_cnt;
  logic         o_cmd_credit;
  logic [6:0]   o_cmd_init_credit;
  logic         o_resp_valid;
  logic [7:0]   o_resp_opcode;
  logic [1:0]   o_resp_dl, o_resp_dp;
  logic [15:0]  o_resp_capptag;
  logic [3:0]   o_resp_code;
  logic         o_rdata_valid, o_rdata_bdi;
  logic [511:0] o_rdata_bus;
  logic         i_tlx_resp_credit = 0, i_tlx_resp_data_credit = 0;
  logic         o_tmpl0, o_tmpl1, o_tmpl2, o_tmpl3;
  logic [3:0]   o_rate0, o_rate1, o_rate2, o_rate3;

  mcp3_afu_top dut (
    .clock_afu(clk), .reset(rst_n),
    .afu_tlx_cmd_valid(o_cmd_valid),
    .afu_tlx_cmd_opcode(o_cmd_opcode),
    .afu_tlx_cmd_actag(o_cmd_actag),
    .afu_tlx_cmd_stream_id(o_cmd_stream_id),
    .afu_tlx_cmd_ea_or_obj(o_cmd_ea),
    .afu_tlx_cmd_afutag(o_cmd_afutag),
    .afu_tlx_cmd_dl(o_cmd_dl),
    .afu_tlx_cmd_pl(o_cmd_pl),
    .afu_tlx_cmd_os(o_cmd_os),
    .afu_tlx_cmd_be(o_cmd_be),
    .afu_tlx_cmd_flag(o_cmd_flag),
    .afu_tlx_cmd_endian(o_cmd_endian),
    .afu_tlx_cmd_bdf(o_cmd_bdf),
    .afu_tlx_cmd_pasid(o_cmd_pasid),
    .afu_tlx_cmd_pg_size(o_cmd_pg_size),
    .afu_tlx_cdata_valid(o_cdata_valid),
    .afu_tlx_cdata_bdi(o_cdata_bdi),
    .afu_tlx_cdata_bus(o_cdata_bus),
    .tlx_afu_cmd_credit(i_cmd_credit),
    .tlx_afu_cmd_data_credit(i_cmd_data_credit),
    .tlx_afu_cmd_resp_initial_credit(i_resp_init),
    .tlx_afu_data_initial_credit(i_data_init),
    .tlx_afu_resp_valid(i_resp_valid),
    .tlx_afu_resp_opcode(i_resp_opcode),
    .tlx_afu_resp_afutag(i_resp_afutag),
    .tlx_afu_resp_code(i_resp_code),
    .tlx_afu_resp_dl(i_resp_dl),
    .tlx_afu_resp_dp(i_resp_dp),
    .tlx_afu_resp_pg_size(i_resp_pg_size),
    .tlx_afu_resp_addr_tag(i_resp_addr_tag),
    .tlx_afu_resp_data_valid(i_resp_data_valid),
    .tlx_afu_resp_data_bdi(i_resp_data_bdi),
    .tlx_afu_resp_data_bus(i_resp_data_bus),
    .afu_tlx_resp_rd_req(o_resp_rd_req),
    .afu_tlx_resp_rd_cnt(o_resp_rd_cnt),
    .afu_tlx_resp_credit(o_resp_credit),
    .afu_tlx_resp_initial_credit(o_resp_init_credit),
    .tlx_afu_ready(i_ready),
    .tlx_afu_cmd_valid(i_cmd_valid),
    .tlx_afu_cmd_opcode(i_cmd_opcode),
    .tlx_afu_cmd_capptag(i_cmd_capptag),
    .tlx_afu_cmd_dl(i_cmd_dl),
    .tlx_afu_cmd_pl(i_cmd_pl),
    .tlx_afu_cmd_be(i_cmd_be),
    .tlx_afu_cmd_end(i_cmd_end),
    .tlx_afu_cmd_t(i_cmd_t),
    .tlx_afu_cmd_pa(i_cmd_pa),
    .tlx_afu_cmd_flag(i_cmd_flag),
    .tlx_afu_cmd_os(i_cmd_os),
    .tlx_afu_cmd_data_valid(i_data_valid),
    .tlx_afu_cmd_data_bdi(i_data_bdi),
    .tlx_afu_cmd_data_bus(i_data_bus),
    .afu_tlx_cmd_rd_req(o_rd_req),
    .afu_tlx_cmd_rd_cnt(o_rd_cnt),
    .afu_tlx_cmd_credit(o_cmd_credit),
    .afu_tlx_cmd_initial_credit(o_cmd_init_credit),
    .afu_tlx_resp_valid(o_resp_valid),
    .afu_tlx_resp_opcode(o_resp_opcode),
    .afu_tlx_resp_dl(o_resp_dl),
    .afu_tlx_resp_capptag(o_resp_capptag),
    .afu_tlx_resp_dp(o_resp_dp),
    .afu_tlx_resp_code(o_resp_code),
    .afu_tlx_rdata_valid(o_rdata_valid),
    .afu_tlx_rdata_bdi(o_rdata_bdi),
    .afu_tlx_rdata_bus(o_rdata_bus),
    .tlx_afu_resp_credit(i_tlx_resp_credit),
    .tlx_afu_resp_data_credit(i_tlx_resp_data_credit),
    .afu_cfg_in_rcv_tmpl_capability_0(1'b1),
    .afu_cfg_in_rcv_tmpl_capability_1(1'b0),
    .afu_cfg_in_rcv_tmpl_capability_2(1'b0),
    .afu_cfg_in_rcv_tmpl_capability_3(1'b0),
    .afu_cfg_in_rcv_rate_capability_0(4'h0),
    .afu_cfg_in_rcv_rate_capability_1(4'h0),
    .afu_cfg_in_rcv_rate_capability_2(4'h0),
    .afu_cfg_in_rcv_rate_capability_3(4'h0),
    .afu_cfg_xmit_tmpl_config_0(o_tmpl0),
    .afu_cfg_xmit_tmpl_config_1(o_tmpl1),
    .afu_cfg_xmit_tmpl_config_2(o_tmpl2),
    .afu_cfg_xmit_tmpl_config_3(o_tmpl3),
    .afu_cfg_xmit_rate_config_0(o_rate0),
    .afu_cfg_xmit_rate_config_1(o_rate1),
    .afu_cfg_xmit_rate_config_2(o_rate2),
    .afu_cfg_xmit_rate_config_3(o_rate3)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] mregs [8];
  bit echo_en = 0;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; also checks the registered echo of tlx_afu_resp_valid.
  task automatic step();
    logic prev;
    prev = i_resp_valid;
    @(posedge clk);
    #1;
    if (echo_en) begin
      chk("resp_cred_echo", o_resp_credit, prev);
      i_resp_valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset(input logic [2:0] rc, input logic [4:0] dc);
    echo_en = 0;
    i_resp_valid = 0;
    i_cmd_valid = 0;
    i_data_valid = 0;
    i_tlx_resp_credit = 0;
    i_tlx_resp_data_credit = 0;
    i_resp_init = rc;
    i_data_init = dc;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_init", o_cmd_init_credit, 7'd1);
    chk("rst_resp_init", o_resp_init_credit, 7'd16);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_opcode", o_resp_opcode, 0);
    chk("rst_rdata_valid", o_rdata_valid, 0);
    chk("rst_rdata_bus", o_rdata_bus, 0);
    chk("rst_cmd_credit", o_cmd_credit, 0);
    chk("rst_rd_req", o_rd_req, 0);
    chk("rst_resp_credit", o_resp_credit, 0);
    chk("rst_init_cmd_valid", o_cmd_valid, 0);
    chk("rst_tmpl0", o_tmpl0, 1);
    chk("rst_tmpl123", {o_tmpl1, o_tmpl2, o_tmpl3}, 0);
    chk("rst_rates", {o_rate0, o_rate1, o_rate2, o_rate3}, 0);
    rst_n = 1;
    step();
    step();
    for (int i = 0; i < 7; i++) mregs[i] = 64'h0;
    mregs[7] = AFU_ID;
    echo_en = 1;
  endtask

  task automatic chk_resp(input logic [7:0] eop, input logic [3:0] ecode,
                          input logic [15:0] etag, input logic erd,
                          input logic [511:0] ebus);
    chk("resp_valid", o_resp_valid, 1);
    chk("resp_opcode", o_resp_opcode, eop);
    chk("resp_code", o_resp_code, ecode);
    chk("resp_capptag", o_resp_capptag, etag);
    chk("resp_dl_dp", {o_resp_dl, o_resp_dp}, 4'b0100);
    chk("resp_cmd_credit", o_cmd_credit, 1);
    chk("rdata_valid", o_rdata_valid, erd);
    chk("rdata_bdi", o_rdata_bdi, 0);
    chk("rdata_bus", o_rdata_bus, ebus);
    i_tlx_resp_credit = 1;
    i_tlx_resp_data_credit = erd;
    step();
    i_tlx_resp_credit = 0;
    i_tlx_resp_data_credit = 0;
    chk("resp_pulse", {o_resp_valid, o_cmd_credit}, 0);
    step();
  endtask

  task automatic txn(input logic [7:0] op, input logic [5:0] pa,
                     input logic [2:0] pl, input logic bdi,
                     input logic [511:0] bus, input int dly);
    logic [15:0]  tag;
    logic         good;
    logic [2:0]   idx;
    logic [7:0]   eop;
    logic [3:0]   ecode;
    logic [511:0] ebus;
    int           n_cc, n_rv;
    tag  = 16'($urandom);
    good = (pl == 3'd3) && (pa[2:0] == 3'd0);
    idx  = pa[5:3];
    ecode = good ? 4'h0 : ((pl != 3'd3) ? 4'h9 : 4'hE);
    ebus = '0;
    i_cmd_valid = 1;
    i_cmd_opcode = op;
    i_cmd_capptag = tag;
    i_cmd_pl = pl;
    i_cmd_pa = {$urandom, $urandom};
    i_cmd_pa[5:0] = pa;
    step();
    i_cmd_valid = 0;
    if (op == 8'h86) begin
      chk("wr_rdreq_early", {o_rd_req, o_resp_valid}, 0);
      step();
      chk("wr_rdreq", o_rd_req, 1);
      chk("wr_rdcnt", o_rd_cnt, 3'b001);
      step();
      chk("wr_rdreq_pulse", o_rd_req, 0);
      for (int k = 0; k < dly; k++) step();
      chk("wr_no_early_resp", o_resp_valid, 0);
      i_data_valid = 1;
      i_data_bdi = bdi;
      i_data_bus = bus;
      step();
      i_data_valid = 0;
      i_data_bdi = 0;
      if (good && !bdi && idx != 3'd7) mregs[idx] = bus[idx*64 +: 64];
      eop = good ? 8'h04 : 8'h05;
      chk_resp(eop, ecode, tag, 1'b0, ebus);
    end else if (op == 8'h28) begin
      chk("rd_early", o_resp_valid, 0);
      step();
      eop = good ? 8'h01 : 8'h02;
      if (good) ebus[idx*64 +: 64] = mregs[idx];
      chk_resp(eop, ecode, tag, good, ebus);
    end else begin
      n_cc = 0;
      n_rv = 0;
      for (int k = 0; k < 6; k++) begin
        n_cc += int'(o_cmd_credit);
        n_rv += int'(o_resp_valid);
        step();
      end
      chk("drop_cmd_credit", n_cc, 1);
      chk("drop_no_resp", n_rv, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [511:0] bus;
    logic [7:0]   op;
    logic [5:0]   pa;
    logic [2:0]   pl;
    int           r, n, found;
    logic [15:0]  tag;

    do_reset(3'd4, 5'd8);

    bus = '0;
    bus[3*64 +: 64] = 64'h0000_0000_DEAD_BEEF;
    txn(8'h86, 6'h18, 3'd3, 1'b0, bus, 0);
    txn(8'h28, 6'h18, 3'd3, 1'b0, '0, 0);
    txn(8'h28, 6'h38, 3'd3, 1'b0, '0, 0);
    txn(8'h28, 6'h04, 3'd3, 1'b0, '0, 0);
    bus[3*64 +: 64] = 64'h1234_5678_9ABC_DEF0;
    txn(8'h86, 6'h18, 3'd2, 1'b0, bus, 1);
    txn(8'h28, 6'h18, 3'd3, 1'b0, '0, 0);
    txn(8'hE0, 6'h00, 3'd3, 1'b0, '0, 0);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = 8'h28;
      else if (r < 8) op = 8'h86;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h28 || op == 8'h86) op = 8'hE0;
      end
      pa = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) pa[2:0] = 3'd0;
      pl = ($urandom_range(0, 4) != 0) ? 3'd3 : 3'($urandom_range(0, 7));
      for (int k = 0; k < 16; k++) bus[k*32 +: 32] = $urandom;
      txn(op, pa, pl, ($urandom_range(0, 7) == 0), bus, $urandom_range(0, 2));
    end

    // No response credit: the read must stall until one is returned.
    do_reset(3'd0, 5'd8);
    tag = 16'hA5C3;
    i_cmd_valid = 1;
    i_cmd_opcode = 8'h28;
    i_cmd_capptag = tag;
    i_cmd_pl = 3'd3;
    i_cmd_pa = 64'h0000_0000_0000_0038;
    step();
    i_cmd_valid = 0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      n += int'(o_resp_valid);
      step();
    end
    chk("nocred_stall", n, 0);
    i_tlx_resp_credit = 1;
    step();
    i_tlx_resp_credit = 0;
    found = 0;
    for (int k = 0; k < 3 && found == 0; k++) begin
      if (o_resp_valid) found = 1;
      else step();
    end
    chk("nocred_resp_after_credit", found, 1);
    if (found == 1) begin
      bus = '0;
      bus[7*64 +: 64] = AFU_ID;
      chk_resp(8'h01, 4'h0, tag, 1'b1, bus);
    end

    echo_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
